dram_bram_responder: RTL and testbench
======================================

Name: dram_bram_responder

Overview:
- Synthesizable, BRAM-backed responder for the DRAM user-side command interface (i_ren/i_wen/i_addr/i_data/i_mask/i_busy in; o_init_calib_complete/o_data/o_data_valid/o_busy out).
- It is the responder end of the interface the RiscV core drives as initiator.
- It substitutes for the DDR3 controller in simulation and on boards without DDR3, with programmable init, read and write latencies.
- The core connects to it without modification.

Parameters:
- APP_ADDR_WIDTH, 28, controller address width; the i_addr port is APP_ADDR_WIDTH-1 bits.
- APP_DATA_WIDTH, 128, beat width in bits.
- APP_MASK_WIDTH, 16, byte-mask width; must equal APP_DATA_WIDTH/8.
- DEPTH_LOG2, 12, log2 of the number of 128-bit beats stored.
- INIT_CYCLES, 16, cycles from reset release to calibration complete; must be >=1.
- READ_LATENCY, 4, cycles from read acceptance to the earliest o_data_valid; must be >=1.
- WRITE_LATENCY, 2, busy cycles after write acceptance; must be >=1.

Ports:
- clock  in  1  single clock.
- reset  in  1  asynchronous, active-high reset.
- i_ren  in  1  read command.
- i_wen  in  1  write command.
- i_addr  in  APP_ADDR_WIDTH-1  address in 16-bit units.
- i_data  in  APP_DATA_WIDTH  write data.
- i_mask  in  APP_MASK_WIDTH  byte mask; 1 = byte NOT written.
- i_busy  in  1  initiator cannot take read data this cycle.
- o_init_calib_complete  out  1  initialisation done.
- o_data  out  APP_DATA_WIDTH  read data.
- o_data_valid  out  1  one-cycle read-data strobe.
- o_busy  out  1  responder cannot accept a command.

Behaviour:
- Reset values: o_busy=1, o_init_calib_complete=0, o_data_valid=0, o_data=0, state=INIT, all counters 0.
- Memory contents are not cleared by reset.
- Beat index = i_addr[DEPTH_LOG2+2:3]. i_addr[2:0] is ignored. Upper address bits are ignored, so addresses wrap modulo 2^DEPTH_LOG2 beats.
- State machine: INIT, IDLE, WRITE, READ_WAIT, READ_RESP.
- INIT:
  - The counter increments every cycle after reset release.
  - When it reaches INIT_CYCLES: go to IDLE, set o_init_calib_complete=1 (sticky until reset), set o_busy=0.
  - Commands during INIT are ignored.
- Acceptance: a command is accepted at the rising edge ending cycle T only if state=IDLE and i_ren|i_wen=1 in cycle T.
  - In IDLE, o_busy=0.
  - Commands presented while o_busy=1 are dropped silently; they are not queued.
- Simultaneous i_ren and i_wen: treated as a write only; the read is dropped.
- Write accepted in cycle T:
  - Each byte b with i_mask[b]=0 is written at the edge ending T; bytes with i_mask[b]=1 keep their old value.
  - State goes to WRITE with o_busy=1 for cycles T+1..T+WRITE_LATENCY, then IDLE.
  - i_mask all-ones: no memory change, same timing.
- Read accepted in cycle T:
  - Address is latched; state goes to READ_WAIT with o_busy=1.
  - After READ_LATENCY-1 cycles in READ_WAIT, state is READ_RESP from cycle T+READ_LATENCY.
  - READ_RESP, i_busy=0: o_data_valid=1 for exactly that cycle with o_data = beat contents; next state IDLE (o_busy=0 the following cycle).
  - READ_RESP, i_busy=1: hold in READ_RESP with o_data_valid=0 and o_busy=1, for as many cycles as needed.
  - Data is read from memory at acceptance, so a read always returns the value at acceptance time.
- o_data holds the last returned beat until the next valid strobe.
- Earliest next acceptance:
  - After a write: cycle T+WRITE_LATENCY+1.
  - After a read: the cycle after the valid strobe.
- Read-after-write: a read accepted in the first legal cycle after a write returns the new data.
- Reset asserted mid-operation: immediate return to INIT with outputs at reset values. An in-flight read is discarded (no strobe). A write already accepted is retained. The INIT_CYCLES count restarts.

Test Plan:
- Init: release reset, idle inputs, INIT_CYCLES=16 -> o_busy=1 and o_init_calib_complete=0 for 16 cycles, then both flip in the same cycle; i_wen pulsed during INIT leaves memory unchanged.
- Write/read: write addr 0x40, data 0x00112233_44556677_8899AABB_CCDDEEFF, mask 0x0000; read addr 0x40 at the first non-busy cycle -> o_data_valid exactly 4 cycles after acceptance with that data; o_busy=1 for 2 cycles after the write.
- Byte mask: after the write above, write addr 0x40 with all-0xFF data and mask 0xFFF0 -> read returns 0x00112233_44556677_8899AABB_FFFFFFFF.
- Backpressure: read with i_busy=1 for 5 cycles starting at T+4 -> no strobe and o_busy=1 during those cycles; single strobe in the first cycle with i_busy=0; o_busy=0 the next cycle.
- Collisions/wrap: i_ren=i_wen=1 -> write occurs and no read strobe; write to addr (1<<15)|0x8 then read addr 0x8 -> same data (DEPTH_LOG2=12 wrap); command while o_busy=1 -> ignored.
- Reset mid-read: assert reset at T+2 of a read -> o_data_valid never asserted, o_data=0, re-init takes 16 cycles, and previously written data is still readable.

Source files
------------

// File: rtl/dram_bram_responder.sv
// dram_bram_responder: BRAM-backed stand-in for the DDR3 user command interface with programmable latencies
module dram_bram_responder #(
  parameter int APP_ADDR_WIDTH = 28,
  parameter int APP_DATA_WIDTH = 128,
  parameter int APP_MASK_WIDTH = 16,
  parameter int DEPTH_LOG2     = 12,
  parameter int INIT_CYCLES    = 16,
  parameter int READ_LATENCY   = 4,
  parameter int WRITE_LATENCY  = 2
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      i_ren,
  input  logic                      i_wen,
  input  logic [APP_ADDR_WIDTH-2:0] i_addr,
  input  logic [APP_DATA_WIDTH-1:0] i_data,
  input  logic [APP_MASK_WIDTH-1:0] i_mask,
  input  logic                      i_busy,
  output logic                      o_init_calib_complete,
  output logic [APP_DATA_WIDTH-1:0] o_data,
  output logic                      o_data_valid,
  output logic                      o_busy
);
  localparam logic [2:0] INIT      = 3'd0;
  localparam logic [2:0] IDLE      = 3'd1;
  localparam logic [2:0] WRITE     = 3'd2;
  localparam logic [2:0] READ_WAIT = 3'd3;
  localparam logic [2:0] READ_RESP = 3'd4;

  logic [2:0] state;
  logic [31:0] cnt;
  logic calib;
  logic [APP_DATA_WIDTH-1:0] mem [0:(1<<DEPTH_LOG2)-1];
  logic [APP_DATA_WIDTH-1:0] rbuf;
  logic [APP_DATA_WIDTH-1:0] hold;
  logic [DEPTH_LOG2-1:0] idx;
  logic accept_w;
  logic accept_r;
  logic unused_addr;

  // Address is in 16-bit units: the low 3 bits select within a beat and upper bits wrap.
  assign idx         = i_addr[DEPTH_LOG2+2:3];
  assign unused_addr = ^i_addr;
  // A simultaneous read and write is taken as a write only.
  assign accept_w    = (state == IDLE) && i_wen;
  assign accept_r    = (state == IDLE) && i_ren && !i_wen;

  assign o_busy                = state != IDLE;
  assign o_init_calib_complete = calib;
  assign o_data_valid          = (state == READ_RESP) && !i_busy;
  assign o_data                = o_data_valid ? rbuf : hold;

  // Byte-masked write and read snapshot at acceptance; storage survives reset.
  always_ff @(posedge clock) begin
    if (accept_w)
      for (int b = 0; b < APP_MASK_WIDTH; b++)
        if (!i_mask[b]) mem[idx][b*8 +: 8] <= i_data[b*8 +: 8];
    if (accept_r) rbuf <= mem[idx];
  end

  // Command sequencing: init countdown, write busy window, read latency and backpressured response.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= INIT;
      cnt   <= '0;
      calib <= 1'b0;
      hold  <= '0;
    end else begin
      case (state)
        INIT:
          if (cnt == INIT_CYCLES - 1) begin
            state <= IDLE;
            cnt   <= '0;
            calib <= 1'b1;
          end else cnt <= cnt + 1;
        IDLE: begin
          cnt <= '0;
          if (i_wen) state <= WRITE;
          else if (i_ren) state <= (READ_LATENCY == 1) ? READ_RESP : READ_WAIT;
        end
        WRITE:
          if (cnt == WRITE_LATENCY - 1) state <= IDLE;
          else cnt <= cnt + 1;
        READ_WAIT:
          if (cnt == READ_LATENCY - 2) state <= READ_RESP;
          else cnt <= cnt + 1;
        READ_RESP:
          if (!i_busy) begin
            state <= IDLE;
            hold  <= rbuf;
          end
        default: state <= INIT;
      endcase
    end
  end
endmodule

// File: tb/tb_dram_bram_responder.sv
// tb_dram_bram_responder: directed self-checking bench for the BRAM DRAM responder
module tb_dram_bram_responder;
  logic clock = 1'b0;
  logic reset = 1'b1;
  logic i_ren = 1'b0;
  logic i_wen = 1'b0;
  logic [26:0] i_addr = '0;
  logic [127:0] i_data = '0;
  logic [15:0] i_mask = '0;
  logic i_busy = 1'b0;
  logic o_init_calib_complete;
  logic [127:0] o_data;
  logic o_data_valid;
  logic o_busy;
  int checks = 0;
  int errors = 0;
  logic done = 1'b0;

  localparam logic [127:0] D1 = 128'h00112233_44556677_8899AABB_CCDDEEFF;
  localparam logic [127:0] DM = 128'h00112233_44556677_8899AABB_FFFFFFFF;
  localparam logic [127:0] D2 = 128'hDEADBEEF_01234567_89ABCDEF_CAFEF00D;
  localparam logic [127:0] D3 = 128'h11111111_22222222_33333333_44444444;
  localparam logic [127:0] D4 = 128'hA5A5A5A5_5A5A5A5A_0F0F0F0F_F0F0F0F0;

  dram_bram_responder dut (
    .clock(clock), .reset(reset), .i_ren(i_ren), .i_wen(i_wen), .i_addr(i_addr),
    .i_data(i_data), .i_mask(i_mask), .i_busy(i_busy),
    .o_init_calib_complete(o_init_calib_complete), .o_data(o_data),
    .o_data_valid(o_data_valid), .o_busy(o_busy)
  );

  always #5 clock = ~clock;

  initial begin
    #200000;
    if (!done) begin
      errors++;
      $error("FAIL timeout: wait expired before test completion");
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
    end
  end

  task automatic cyc();
    @(posedge clock);
    #2;
  endtask

  task automatic init_seq(input logic poke);
    reset = 1'b0;
    for (int i = 0; i < 16; i++) begin
      i_wen  = poke && (i == 3);
      i_addr = 27'h40;
      i_data = '0;
      i_mask = '0;
      #1;
      checks++; if (o_busy !== 1'b1) begin errors++; $error("FAIL init_busy observed=%0h", o_busy); end
      checks++; if (o_init_calib_complete !== 1'b0) begin errors++; $error("FAIL init_calib observed=%0h", o_init_calib_complete); end
      checks++; if (o_data_valid !== 1'b0) begin errors++; $error("FAIL init_valid observed=%0h", o_data_valid); end
      cyc();
    end
    i_wen = 1'b0;
    #1;
    checks++; if (o_busy !== 1'b0) begin errors++; $error("FAIL init_done_busy observed=%0h", o_busy); end
    checks++; if (o_init_calib_complete !== 1'b1) begin errors++; $error("FAIL init_done_calib observed=%0h", o_init_calib_complete); end
  endtask

  task automatic do_write(input logic [26:0] addr, input logic [127:0] data,
                          input logic [15:0] mask, input logic ren_too, input logic poke);
    i_wen = 1'b1; i_ren = ren_too; i_addr = addr; i_data = data; i_mask = mask;
    #1;
    checks++; if (o_busy !== 1'b0) begin errors++; $error("FAIL wr_accept_busy observed=%0h", o_busy); end
    cyc();
    i_wen = poke; i_ren = poke; i_addr = 27'h40; i_data = '0; i_mask = '0;
    for (int i = 1; i <= 2; i++) begin
      #1;
      checks++; if (o_busy !== 1'b1) begin errors++; $error("FAIL wr_busy observed=%0h", o_busy); end
      checks++; if (o_data_valid !== 1'b0) begin errors++; $error("FAIL wr_no_valid observed=%0h", o_data_valid); end
      cyc();
      i_wen = 1'b0; i_ren = 1'b0;
    end
    #1;
    checks++; if (o_busy !== 1'b0) begin errors++; $error("FAIL wr_done_busy observed=%0h", o_busy); end
    checks++; if (o_data_valid !== 1'b0) begin errors++; $error("FAIL wr_done_valid observed=%0h", o_data_valid); end
  endtask

  task automatic do_read(input logic [26:0] addr, input logic [127:0] exp, input int nbusy);
    i_ren = 1'b1; i_addr = addr;
    #1;
    checks++; if (o_busy !== 1'b0) begin errors++; $error("FAIL rd_accept_busy observed=%0h", o_busy); end
    cyc();
    i_ren = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      #1;
      checks++; if (o_data_valid !== 1'b0) begin errors++; $error("FAIL rd_wait_valid observed=%0h", o_data_valid); end
      checks++; if (o_busy !== 1'b1) begin errors++; $error("FAIL rd_wait_busy observed=%0h", o_busy); end
      cyc();
    end
    for (int i = 0; i < nbusy; i++) begin
      i_busy = 1'b1;
      #1;
      checks++; if (o_data_valid !== 1'b0) begin errors++; $error("FAIL rd_bp_valid observed=%0h", o_data_valid); end
      checks++; if (o_busy !== 1'b1) begin errors++; $error("FAIL rd_bp_busy observed=%0h", o_busy); end
      cyc();
    end
    i_busy = 1'b0;
    #1;
    checks++; if (o_data_valid !== 1'b1) begin errors++; $error("FAIL rd_strobe observed=%0h", o_data_valid); end
    checks++; if (o_data !== exp) begin errors++; $error("FAIL rd_data observed=%0h expected=%0h", o_data, exp); end
    cyc();
    #1;
    checks++; if (o_busy !== 1'b0) begin errors++; $error("FAIL rd_after_busy observed=%0h", o_busy); end
    checks++; if (o_data_valid !== 1'b0) begin errors++; $error("FAIL rd_after_valid observed=%0h", o_data_valid); end
    checks++; if (o_data !== exp) begin errors++; $error("FAIL rd_hold_data observed=%0h expected=%0h", o_data, exp); end
  endtask

  initial begin
    cyc();
    cyc();
    #1;
    checks++; if (o_busy !== 1'b1) begin errors++; $error("FAIL rst_busy observed=%0h", o_busy); end
    checks++; if (o_init_calib_complete !== 1'b0) begin errors++; $error("FAIL rst_calib observed=%0h", o_init_calib_complete); end
    checks++; if (o_data_valid !== 1'b0) begin errors++; $error("FAIL rst_valid observed=%0h", o_data_valid); end
    checks++; if (o_data !== 128'h0) begin errors++; $error("FAIL rst_data observed=%0h", o_data); end
    init_seq(1'b0);
    do_write(27'h40, D1, 16'h0000, 1'b0, 1'b0);
    do_read(27'h40, D1, 0);
    do_write(27'h40, {128{1'b1}}, 16'hFFF0, 1'b0, 1'b0);
    do_read(27'h40, DM, 0);
    do_read(27'h40, DM, 5);
    do_write(27'h100, D2, 16'h0000, 1'b0, 1'b1);
    do_read(27'h40, DM, 0);
    do_read(27'h100, D2, 0);
    do_write(27'h200, D3, 16'h0000, 1'b1, 1'b0);
    do_read(27'h200, D3, 0);
    do_write(27'h200, D1, 16'hFFFF, 1'b0, 1'b0);
    do_read(27'h200, D3, 0);
    do_write(27'h8008, D4, 16'h0000, 1'b0, 1'b0);
    do_read(27'h8, D4, 0);
    i_ren = 1'b1; i_addr = 27'h8;
    cyc();
    i_ren = 1'b0;
    cyc();
    reset = 1'b1;
    #1;
    checks++; if (o_busy !== 1'b1) begin errors++; $error("FAIL mid_rst_busy observed=%0h", o_busy); end
    checks++; if (o_init_calib_complete !== 1'b0) begin errors++; $error("FAIL mid_rst_calib observed=%0h", o_init_calib_complete); end
    checks++; if (o_data_valid !== 1'b0) begin errors++; $error("FAIL mid_rst_valid observed=%0h", o_data_valid); end
    checks++; if (o_data !== 128'h0) begin errors++; $error("FAIL mid_rst_data observed=%0h", o_data); end
    cyc();
    #1;
    checks++; if (o_data_valid !== 1'b0) begin errors++; $error("FAIL mid_rst_valid2 observed=%0h", o_data_valid); end
    cyc();
    init_seq(1'b1);
    checks++; if (o_data !== 128'h0) begin errors++; $error("FAIL reinit_data observed=%0h", o_data); end
    do_read(27'h8, D4, 0);
    do_read(27'h40, DM, 0);
    done = 1'b1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
